// File: rtl/logic_unit_iter.sv
// logic_unit_iter: multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
// Processes one SLICE-bit chunk per cycle, LSB slice first, between an
// input handshake (accepted only in IDLE) and an output handshake (DONE).
// Optional feature macro: LOGIC_UNIT_ZERO_FLAG_EN adds a registered
// 'zero' output accumulated slice by slice.
//
// Handshake semantics: a transfer happens on a rising edge where both
// valid and ready are high. in_ready is high only in IDLE; out_valid is
// high only in DONE. Both come straight from the state register, so there
// is no combinational path from in_valid to out_valid or from out_ready
// to in_ready.
module logic_unit_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // A slice width that does not tile the word is a build error.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("logic_unit_iter: SLICE must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [1:0]        op_q;
  logic [SLICE-1:0]  sa, sb, sr;
  logic              last;
  int                idx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign last      = (cnt == CW'(N - 1));

  // Select the current operand slice and apply the latched op to it.
  always_comb begin
    idx = int'(cnt) * SLICE;
    sa  = a_q[idx +: SLICE];
    sb  = b_q[idx +: SLICE];
    sr  = '0;
    case (op_q)
      OP_AND:  sr = sa & sb;
      OP_OR:   sr = sa | sb;
      OP_XOR:  sr = sa ^ sb;
      OP_NOR:  sr = ~(sa | sb);
      default: sr = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: accept in IDLE, N cycles of BUSY, hold DONE until taken.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, write one result slice per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
          end
        end
        BUSY: begin
          result[idx +: SLICE] <= sr;
          // Counter stops at N-1; it is cleared again on the next accept.
          if (!last) cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (out_ready) cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  // Zero flag: set on accept, cleared by any non-zero slice during BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b1;
    end else if (state == IDLE && in_valid) begin
      zero <= 1'b1;
    end else if (state == BUSY) begin
      zero <= zero & (sr == '0);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_iter.sv
// Testbench for logic_unit_iter: WIDTH=32/SLICE=8 main instance plus a
// WIDTH=32/SLICE=32 instance for the single-slice case.
module tb_logic_unit_iter;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (SLICE=8) ----------------
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0]   op = 2'b00, dbg_state;
  logic [W-1:0] a = '0, b = '0, result;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero;
`endif

  logic_unit_iter #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .zero(zero),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (SLICE=32) ----------------
  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [1:0]   op1 = 2'b00, dbg_state1;
  logic [W-1:0] a1 = '0, b1 = '0, result1;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero1;
`endif

  logic_unit_iter #(.WIDTH(32), .SLICE(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .op(op1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .zero(zero1),
`endif
    .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] ref_op(logic [W-1:0] x, logic [W-1:0] y, logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check 4-cycle latency and result, hold DONE for 'hold' cycles.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top,
                       input int hold);
    int n;
    logic [W-1:0] expv;
    exp_q.push_back(ref_op(ta, tb_, top));
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", W'(in_ready), W'(1));
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      tick();
      n++;
    end
    in_valid = 1'b0;
    expv = exp_q.pop_front();
    chk("latency", W'(n), W'(4));
    chk("result", result, expv);
    chk("in_ready_done", W'(in_ready), W'(0));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("zero", W'(zero), W'(expv == '0));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'h1; b = $urandom; op = 2'($urandom_range(0, 3));
      tick();
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_result", result, expv);
      chk("hold_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", W'(out_valid), W'(0));
    chk("release_in_ready", W'(in_ready), W'(1));
    chk("idle_result_held", result, expv);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    chk("rst_result", result, '0);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("rst_zero", W'(zero), W'(1));
`endif
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    do_op(32'hF0F01234, 32'h0FF0FFFF, 2'b00, 0);
    chk("vec_and", result, 32'h00F01234);
    do_op(32'hF0F01234, 32'h0FF0FFFF, 2'b01, 0);
    chk("vec_or", result, 32'hFFF0FFFF);
    do_op(32'hF0F01234, 32'h0FF0FFFF, 2'b10, 0);
    chk("vec_xor", result, 32'hFF00EDCB);
    do_op(32'h0, 32'h0, 2'b11, 5);
    chk("vec_nor", result, 32'hFFFFFFFF);
    do_op(32'hAAAAAAAA, 32'h55555555, 2'b00, 1);
    chk("vec_alt_and", result, 32'h0);
    do_op(32'hAAAAAAAA, 32'h55555555, 2'b01, 0);
    chk("vec_alt_or", result, 32'hFFFFFFFF);

    // Reset during the second BUSY cycle.
    a = 32'h13579BDF; b = 32'hFFFFFFFF; op = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", result, '0);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    #2 rst_n = 1'b1;
    tick();
    do_op(32'h12345678, 32'h0F0F0F0F, 2'b10, 2);
    chk("post_rst_xor", result, 32'h1D3B5977);

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++)
      do_op($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));

    // Single-slice instance: result one cycle after accept.
    a1 = 32'h12345678; b1 = 32'hFFFF0000; op1 = 2'b00; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("s32_busy_valid", W'(out_valid1), W'(0));
    tick();
    chk("s32_valid", W'(out_valid1), W'(1));
    chk("s32_result", result1, 32'h12340000);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("s32_zero", W'(zero1), W'(0));
`endif
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("s32_in_ready", W'(in_ready1), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_unit_iter.md
Name: logic_unit_iter

Overview:
- Parametrised, multi-cycle bitwise logic unit. Successor to the fixed 32-bit single-op gate arrays in the ALU.
- Accepts two WIDTH-bit operands and a 2-bit opcode over a valid/ready handshake.
- Computes AND/OR/XOR/NOR one SLICE-bit chunk per cycle, LSB slice first.
- Presents the full result on an output valid/ready handshake. Sits beside the adder/shifter in the ALU datapath where area matters more than latency.

Parameters:
- WIDTH, 32: operand and result width in bits.
- SLICE, 8: bits processed per cycle. Must divide WIDTH exactly; otherwise elaboration fails via generate-time error. N = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  unit can accept (high only in IDLE)
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result

Behaviour:
- Reset (async assert, rst_n low): state=IDLE, slice counter=0, result=0, out_valid=0, in_ready=1, operand/op registers=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: latch a, b, op; counter=0; go BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle writes result[k*SLICE +: SLICE] = op(a_slice_k, b_slice_k) for k=counter, then counter++.
  - Bits of result outside slice k hold their value.
  - After slice N-1 is written, go DONE. BUSY lasts exactly N cycles.
- DONE:
  - out_valid=1; result stable.
  - On out_valid&out_ready: go IDLE, counter=0.
  - out_valid stays high and result holds for as long as out_ready is low.
- Latency: accept at edge T gives out_valid high after edge T+N.
  - With out_ready held high, DONE lasts one cycle; next accept no earlier than edge T+N+2. Throughput is one op per N+2 cycles.
- Inputs are ignored while not IDLE. in_valid during BUSY/DONE has no effect; a, b and op may change freely there.
- The op is latched at accept. Changing op mid-operation has no effect.
- result retains its last value in IDLE until the next BUSY overwrites it slice by slice. Intermediate values during BUSY are not valid for consumers.
- SLICE==WIDTH: N=1. BUSY lasts a single cycle; counter is 1 bit wide or optimised away.
- Counter width is clog2(N), minimum 1. No wrap-around: the counter is cleared on entry to BUSY and never exceeds N-1.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values. No partial result survives.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

Optional Feature:
- Macro: LOGIC_UNIT_ZERO_FLAG_EN.
- Defined:
  - Extra output port zero (output, 1 bit).
  - zero is a registered flag, equal to 1 iff every result bit is 0. It is accumulated per slice during BUSY: cleared to 1 on accept, ANDed with slice-is-zero each BUSY cycle.
  - zero is valid whenever out_valid=1 and held with result. Reset value 1.
- Undefined: port zero absent; no accumulation logic. All other behaviour identical.

Test Plan:
- WIDTH=32, SLICE=8; a=0xF0F01234, b=0x0FF0FFFF, op=00 -> out_valid exactly 4 cycles after accept; result=0x00F01234.
- Same operands, op=01 -> result=0xFFF0FFFF. op=10 -> result=0xFF00EDCB. a=b=0, op=11 -> result=0xFFFFFFFF.
- out_ready held low 5 cycles in DONE -> out_valid and result stable. in_valid pulsed meanwhile with a=0x1 -> ignored, in_ready=0. Release out_ready -> IDLE next cycle.
- rst_n pulsed low during 2nd BUSY cycle -> result=0, out_valid=0, in_ready=1 asynchronously. A fresh op then completes correctly with 4-cycle latency.
- SLICE=32 build; a=0x12345678, b=0xFFFF0000, op=00 -> result=0x12340000 one cycle after accept. SLICE=3 with WIDTH=32 -> elaboration error.
- With LOGIC_UNIT_ZERO_FLAG_EN: a=0xAAAAAAAA, b=0x55555555, op=00 -> result=0, zero=1. op=01 -> result=0xFFFFFFFF, zero=0.
